// File: rtl/nn_img_pkg.sv
// nn_img_pkg: shared definitions for the image-buffer slice (buffer, DMA
// writer, read sequencer).
//   DATA_WIDTH       bits per pixel
//   ADDR_WIDTH       image-buffer address width
//   TOTAL_DATA_WIDTH buffer word width (6 pixels)
//   REP_WIDTH        width of the read-pass repeat count
//   img_rd_state_e   read-sequencer FSM encoding
package nn_img_pkg;

  localparam int unsigned DATA_WIDTH       = 8;
  localparam int unsigned ADDR_WIDTH       = 10;
  localparam int unsigned TOTAL_DATA_WIDTH = DATA_WIDTH * 6;
  localparam int unsigned REP_WIDTH        = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } img_rd_state_e;

endpackage

// File: rtl/nn_img_addr_gen.sv
// nn_img_addr_gen: nested rep/row/col address walker for the image reader.
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_load          latch window parameters and restart at i_base
//   i_advance       step to the next address of the window
//   i_base/i_rows/i_cols/i_stride/i_reps  window description
//   o_addr          current address (row_start + col, mod 2^ADDR_WIDTH)
//   o_last          current address is the final one of the final pass
module nn_img_addr_gen #(
  parameter int unsigned ADDR_WIDTH = nn_img_pkg::ADDR_WIDTH,
  parameter int unsigned REP_WIDTH  = nn_img_pkg::REP_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic                  i_advance,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [ADDR_WIDTH-1:0] i_rows,
  input  logic [ADDR_WIDTH-1:0] i_cols,
  input  logic [ADDR_WIDTH-1:0] i_stride,
  input  logic [REP_WIDTH-1:0]  i_reps,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_last
);
  import nn_img_pkg::*;

  logic [ADDR_WIDTH-1:0] base_q, rows_q, cols_q, stride_q;
  logic [REP_WIDTH-1:0]  reps_q;
  logic [ADDR_WIDTH-1:0] row_q, col_q, row_start_q;
  logic [REP_WIDTH-1:0]  rep_q;

  logic last_col, last_row, last_rep;

  always_comb begin
    last_col = (col_q == cols_q - ADDR_WIDTH'(1));
    last_row = (row_q == rows_q - ADDR_WIDTH'(1));
    last_rep = (rep_q == reps_q - REP_WIDTH'(1));
    o_last   = last_col && last_row && last_rep;
    o_addr   = row_start_q + col_q;
  end

  // Counters freeze on the final address so o_addr keeps showing it while
  // the sequencer drains and idles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      base_q      <= '0;
      rows_q      <= '0;
      cols_q      <= '0;
      stride_q    <= '0;
      reps_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      rep_q       <= '0;
      row_start_q <= '0;
    end else if (i_load) begin
      base_q      <= i_base;
      rows_q      <= i_rows;
      cols_q      <= i_cols;
      stride_q    <= i_stride;
      reps_q      <= i_reps;
      row_q       <= '0;
      col_q       <= '0;
      rep_q       <= '0;
      row_start_q <= i_base;
    end else if (i_advance && !o_last) begin
      if (last_col) begin
        col_q <= '0;
        if (last_row) begin
          row_q       <= '0;
          rep_q       <= rep_q + REP_WIDTH'(1);
          row_start_q <= base_q;
        end else begin
          row_q       <= row_q + ADDR_WIDTH'(1);
          row_start_q <= row_start_q + stride_q;
        end
      end else begin
        col_q <= col_q + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/nn_img_rd.sv
// nn_img_rd: image-buffer read sequencer feeding the PE array.
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_start + window    command (base, rows, cols, stride, reps), IDLE only
//   i_wr_busy           buffer is being written; no reads may issue
//   o_rd_en/o_rd_addr   buffer read port; i_rd_data returns same cycle
//   o_data/o_valid/i_ready/o_last  output stream, o_last on final word
//   o_busy, o_done      command in progress / one-cycle completion pulse
module nn_img_rd #(
  parameter int unsigned DATA_WIDTH       = nn_img_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH       = nn_img_pkg::ADDR_WIDTH,
  parameter int unsigned TOTAL_DATA_WIDTH = DATA_WIDTH * 6,
  parameter int unsigned REP_WIDTH        = nn_img_pkg::REP_WIDTH
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic [ADDR_WIDTH-1:0]       i_base,
  input  logic [ADDR_WIDTH-1:0]       i_rows,
  input  logic [ADDR_WIDTH-1:0]       i_cols,
  input  logic [ADDR_WIDTH-1:0]       i_stride,
  input  logic [REP_WIDTH-1:0]        i_reps,
  input  logic                        i_wr_busy,
  output logic                        o_rd_en,
  output logic [ADDR_WIDTH-1:0]       o_rd_addr,
  input  logic [TOTAL_DATA_WIDTH-1:0] i_rd_data,
  output logic [TOTAL_DATA_WIDTH-1:0] o_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_last,
  output logic                        o_busy,
  output logic                        o_done
);
  import nn_img_pkg::*;

  img_rd_state_e state_q, state_d;

  logic zero_cmd, accept, gen_load, gen_last, final_hs;

  always_comb begin
    zero_cmd = (i_rows == '0) || (i_cols == '0) || (i_reps == '0);
    accept   = (state_q == ST_IDLE) && i_start;
    gen_load = accept && !zero_cmd;
    final_hs = o_valid && i_ready && o_last;
  end

  nn_img_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .REP_WIDTH  (REP_WIDTH)
  ) u_addr_gen (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (gen_load),
    .i_advance (o_rd_en),
    .i_base    (i_base),
    .i_rows    (i_rows),
    .i_cols    (i_cols),
    .i_stride  (i_stride),
    .i_reps    (i_reps),
    .o_addr    (o_rd_addr),
    .o_last    (gen_last)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (gen_load)            state_d = ST_RUN;
      ST_RUN:   if (o_rd_en && gen_last) state_d = ST_DRAIN;
      ST_DRAIN: if (final_hs)            state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: a read issues only when the output register can take it.
  always_comb begin
    o_busy  = (state_q != ST_IDLE);
    o_rd_en = (state_q == ST_RUN) && !i_wr_busy && (!o_valid || i_ready);
  end

  // Output register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data  <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= (accept && zero_cmd) || ((state_q == ST_DRAIN) && final_hs);
      if (o_rd_en) begin
        o_data  <= i_rd_data;
        o_valid <= 1'b1;
        o_last  <= gen_last;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
    end
  end

endmodule
